// File: rtl/bram_write_arbiter_pkg.sv
// Shared definitions for bram_write_arbiter: grant encoding, fill FSM states and clogb2.
// Optional feature macro used by this slice: BRAM_ARB_FIXED_PRIO_EN.
package bram_write_arbiter_pkg;

  localparam logic GRANT_LITE   = 1'b0;
  localparam logic GRANT_STREAM = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // Ceiling log2; clogb2(1) = 0, clogb2(4) = 2.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_write_arbiter_arb.sv
// bram_rr_arb2: two-input arbiter (lite vs stream) returning one-hot grants.
// BRAM_ARB_FIXED_PRIO_EN selects lite-always-wins instead of round-robin.
module bram_rr_arb2
  import bram_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_l,
  input  logic i_req_t,
  output logic o_gnt_l,
  output logic o_gnt_t
);

  logic r_last_grant;

  always_comb begin
    o_gnt_l = 1'b0;
    o_gnt_t = 1'b0;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    o_gnt_l = i_req_l;
    o_gnt_t = i_req_t & ~i_req_l;
`else
    if (i_req_l && i_req_t) begin
      // On contention the requester that did not win last time goes first.
      if (r_last_grant == GRANT_LITE) begin
        o_gnt_t = 1'b1;
      end else begin
        o_gnt_l = 1'b1;
      end
    end else begin
      o_gnt_l = i_req_l;
      o_gnt_t = i_req_t;
    end
`endif
  end

  // Starts as STREAM so the first contended cycle after reset goes to lite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GRANT_STREAM;
    end else if (o_gnt_l) begin
      r_last_grant <= GRANT_LITE;
    end else if (o_gnt_t) begin
      r_last_grant <= GRANT_STREAM;
    end
  end

endmodule

// File: rtl/bram_write_arbiter.sv
// Shares BRAM port A between an AXI4-Lite write slave and an AXI4-Stream window filler.
// Build option BRAM_ARB_FIXED_PRIO_EN (inside bram_rr_arb2) gives lite fixed priority.
module bram_write_arbiter
  import bram_write_arbiter_pkg::*;
#(
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_ADDR_WIDTH   = 16,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          cfg_start,
  input  logic [BRAM_ADDR_WIDTH-1:0]    cfg_base,
  input  logic [BRAM_ADDR_WIDTH:0]      cfg_length,
  output logic                          sts_busy,
  output logic                          sts_done,
  output logic                          bram_porta_clk,
  output logic                          bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]    bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0]  bram_porta_we,
  output logic                          o_dbg_state
);

  localparam int ADDR_LSB = clogb2(AXI_DATA_WIDTH / 8);

  // Handshakes: a transfer happens in the cycle where valid and ready are both
  // high; ready is the arbiter grant, so AW and W are accepted together or not at all.
  fsm_state_t                   r_state;
  fsm_state_t                   w_state_next;
  logic                         w_load;
  logic                         w_done_next;
  logic [BRAM_ADDR_WIDTH-1:0]   r_ptr;
  logic [BRAM_ADDR_WIDTH:0]     r_remaining;
  logic                         r_done;
  logic                         r_bvalid;
  logic [BRAM_ADDR_WIDTH-1:0]   r_addr;
  logic [BRAM_DATA_WIDTH-1:0]   r_wrdata;
  logic [BRAM_DATA_WIDTH/8-1:0] r_we;
  logic                         w_req_l;
  logic                         w_req_t;
  logic                         w_gnt_l;
  logic                         w_gnt_t;

  // Lite may only be granted when its response slot is free or draining now.
  assign w_req_l = s_axi_awvalid & s_axi_wvalid & (~r_bvalid | s_axi_bready);
  assign w_req_t = (r_state == RUN) & s_axis_tvalid;

  bram_rr_arb2 u_arb (
    .clk     (aclk),
    .rst     (areset),
    .i_req_l (w_req_l),
    .i_req_t (w_req_t),
    .o_gnt_l (w_gnt_l),
    .o_gnt_t (w_gnt_t)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_length != '0) begin
            w_state_next = RUN;
            w_load       = 1'b1;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_gnt_t && (r_remaining == (BRAM_ADDR_WIDTH+1)'(1))) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Pointer wraps at the BRAM top by plain overflow of its width.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ptr       <= '0;
      r_remaining <= '0;
    end else if (w_load) begin
      r_ptr       <= cfg_base;
      r_remaining <= cfg_length;
    end else if (w_gnt_t) begin
      r_ptr       <= r_ptr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_next;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_addr   <= '0;
      r_wrdata <= '0;
      r_we     <= '0;
    end else if (w_gnt_l) begin
      r_addr   <= s_axi_awaddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
      r_wrdata <= s_axi_wdata;
      r_we     <= s_axi_wstrb;
    end else if (w_gnt_t) begin
      r_addr   <= r_ptr;
      r_wrdata <= s_axis_tdata;
      r_we     <= '1;
    end else begin
      r_we     <= '0;
    end
  end

  // A new grant wins over a response drain in the same cycle, keeping bvalid high.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_bvalid <= 1'b0;
    end else if (w_gnt_l) begin
      r_bvalid <= 1'b1;
    end else if (s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  assign s_axi_awready     = w_gnt_l;
  assign s_axi_wready      = w_gnt_l;
  assign s_axi_bresp       = RESP_OKAY;
  assign s_axi_bvalid      = r_bvalid;
  assign s_axis_tready     = w_gnt_t;
  assign sts_busy          = (r_state == RUN);
  assign sts_done          = r_done;
  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = areset;
  assign bram_porta_addr   = r_addr;
  assign bram_porta_wrdata = r_wrdata;
  assign bram_porta_we     = r_we;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed bench for bram_write_arbiter: lite writes, stream fills, contention,
// backpressure, zero-length/re-arm and asynchronous reset mid-fill.
module tb_bram_write_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        cfg_start;
  logic [9:0]  cfg_base;
  logic [10:0] cfg_length;
  logic        sts_busy;
  logic        sts_done;
  logic        bram_porta_clk;
  logic        bram_porta_rst;
  logic [9:0]  bram_porta_addr;
  logic [31:0] bram_porta_wrdata;
  logic [3:0]  bram_porta_we;
  logic        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  bram_write_arbiter dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_axi_awaddr      (s_axi_awaddr),
    .s_axi_awvalid     (s_axi_awvalid),
    .s_axi_awready     (s_axi_awready),
    .s_axi_wdata       (s_axi_wdata),
    .s_axi_wstrb       (s_axi_wstrb),
    .s_axi_wvalid      (s_axi_wvalid),
    .s_axi_wready      (s_axi_wready),
    .s_axi_bresp       (s_axi_bresp),
    .s_axi_bvalid      (s_axi_bvalid),
    .s_axi_bready      (s_axi_bready),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .cfg_start         (cfg_start),
    .cfg_base          (cfg_base),
    .cfg_length        (cfg_length),
    .sts_busy          (sts_busy),
    .sts_done          (sts_done),
    .bram_porta_clk    (bram_porta_clk),
    .bram_porta_rst    (bram_porta_rst),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_wrdata (bram_porta_wrdata),
    .bram_porta_we     (bram_porta_we),
    .o_dbg_state       (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    logic [9:0] exp_ptr;
    int         beats;

    areset        = 1'b1;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    cfg_start     = 1'b0;
    cfg_base      = '0;
    cfg_length    = '0;

    // Reset state
    #1;
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_bresp", s_axi_bresp, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_busy", sts_busy, 0);
    chk("rst_done", sts_done, 0);
    chk("rst_addr", bram_porta_addr, 0);
    chk("rst_wrdata", bram_porta_wrdata, 0);
    chk("rst_we", bram_porta_we, 0);
    chk("rst_porta_rst", bram_porta_rst, 1);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
    chk("rel_porta_rst", bram_porta_rst, 0);

    // Lite only
    s_axi_awaddr = 16'h0010; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1;
    chk("lite_awready", s_axi_awready, 1);
    chk("lite_wready", s_axi_wready, 1);
    tick;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("lite_addr", bram_porta_addr, 10'h004);
    chk("lite_wrdata", bram_porta_wrdata, 32'hDEADBEEF);
    chk("lite_we", bram_porta_we, 4'hF);
    chk("lite_bvalid", s_axi_bvalid, 1);
    chk("lite_bresp", s_axi_bresp, 0);
    tick;
    chk("lite_we_off", bram_porta_we, 0);
    chk("lite_addr_hold", bram_porta_addr, 10'h004);
    chk("lite_bvalid_hold", s_axi_bvalid, 1);
    s_axi_bready = 1'b1;
    tick;
    chk("lite_bvalid_drop", s_axi_bvalid, 0);
    s_axi_bready = 1'b0;

    // Stream fill wrapping at BRAM top
    cfg_base = 10'h3FE; cfg_length = 11'd4; cfg_start = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'd1;
    #1;
    chk("fill_tready_idle", s_axis_tready, 0);
    chk("fill_busy_pre", sts_busy, 0);
    tick;
    cfg_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_axis_tdata = 32'(i);
      #1;
      chk("fill_busy", sts_busy, 1);
      chk("fill_tready", s_axis_tready, 1);
      tick;
      chk("fill_addr", bram_porta_addr, 10'(10'h3FE + i - 1));
      chk("fill_wrdata", bram_porta_wrdata, 32'(i));
      chk("fill_we", bram_porta_we, 4'hF);
      chk("fill_done", sts_done, (i == 4));
    end
    chk("fill_busy_end", sts_busy, 0);
    s_axis_tvalid = 1'b0;
    tick;
    chk("fill_done_pulse", sts_done, 0);
    chk("fill_we_off", bram_porta_we, 0);

    // Contention
`ifdef BRAM_ARB_FIXED_PRIO_EN
    pat = 4'b1111;
`else
    pat = 4'b0101;
`endif
    cfg_base = 10'h100; cfg_length = 11'd4; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    s_axi_awaddr = 16'h0200; s_axi_wstrb = 4'hF; s_axi_bready = 1'b1;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axis_tvalid = 1'b1;
    exp_ptr = 10'h100;
    for (int i = 0; i < 4; i++) begin
      s_axi_wdata = 32'hA0 + 32'(i);
      s_axis_tdata = 32'hB0 + 32'(i);
      #1;
      chk("cont_awready", s_axi_awready, pat[i]);
      chk("cont_tready", s_axis_tready, !pat[i]);
      tick;
      if (pat[i]) begin
        chk("cont_lite_addr", bram_porta_addr, 10'h080);
        chk("cont_lite_data", bram_porta_wrdata, 32'hA0 + 32'(i));
      end else begin
        chk("cont_strm_addr", bram_porta_addr, exp_ptr);
        chk("cont_strm_data", bram_porta_wrdata, 32'hB0 + 32'(i));
        exp_ptr = exp_ptr + 1'b1;
      end
      chk("cont_we", bram_porta_we, 4'hF);
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    beats = 0;
    for (int k = 0; k < 8; k++) begin
      s_axis_tdata = 32'hC0 + 32'(k);
      tick;
      chk("drain_addr", bram_porta_addr, exp_ptr);
      chk("drain_data", bram_porta_wrdata, 32'hC0 + 32'(k));
      exp_ptr = exp_ptr + 1'b1;
      beats++;
      if (sts_done) break;
    end
    chk("drain_done", sts_done, 1);
    chk("drain_end_ptr", exp_ptr, 10'h104);
    s_axis_tvalid = 1'b0;
    tick;
    chk("cont_bvalid_clear", s_axi_bvalid, 0);

    // Backpressure on the write response
    cfg_base = 10'h020; cfg_length = 11'd3; cfg_start = 1'b1; s_axi_bready = 1'b0;
    tick;
    cfg_start = 1'b0;
    s_axi_awaddr = 16'h0040; s_axi_wdata = 32'h11; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hE0;
    #1;
    chk("bp_first_awready", s_axi_awready, 1);
    chk("bp_first_tready", s_axis_tready, 0);
    tick;
    chk("bp_first_addr", bram_porta_addr, 10'h010);
    s_axi_awaddr = 16'h0044; s_axi_wdata = 32'h22;
    for (int i = 0; i < 2; i++) begin
      s_axis_tdata = 32'hE0 + 32'(i);
      #1;
      chk("bp_awready_blocked", s_axi_awready, 0);
      chk("bp_tready", s_axis_tready, 1);
      tick;
      chk("bp_strm_addr", bram_porta_addr, 10'(10'h020 + i));
      chk("bp_strm_data", bram_porta_wrdata, 32'hE0 + 32'(i));
      chk("bp_bvalid_held", s_axi_bvalid, 1);
    end
    s_axi_bready = 1'b1; s_axis_tdata = 32'hE2;
    #1;
    chk("bp_release_awready", s_axi_awready, 1);
    chk("bp_release_tready", s_axis_tready, 0);
    tick;
    chk("bp_second_addr", bram_porta_addr, 10'h011);
    chk("bp_second_data", bram_porta_wrdata, 32'h22);
    chk("bp_bvalid_stays", s_axi_bvalid, 1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick;
    chk("bp_last_addr", bram_porta_addr, 10'h022);
    chk("bp_last_done", sts_done, 1);
    chk("bp_bvalid_done", s_axi_bvalid, 0);
    s_axis_tvalid = 1'b0; s_axi_bready = 1'b0;

    // Zero length
    cfg_base = 10'h055; cfg_length = 11'd0; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    chk("zero_done", sts_done, 1);
    chk("zero_we", bram_porta_we, 0);
    chk("zero_busy", sts_busy, 0);
    tick;
    chk("zero_done_clear", sts_done, 0);

    // Re-arm during RUN is ignored
    cfg_base = 10'h050; cfg_length = 11'd2; cfg_start = 1'b1;
    tick;
    chk("rearm_busy", sts_busy, 1);
    cfg_base = 10'h070; cfg_length = 11'd5;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hC1;
    tick;
    cfg_start = 1'b0;
    chk("rearm_addr0", bram_porta_addr, 10'h050);
    s_axis_tdata = 32'hC2;
    tick;
    chk("rearm_addr1", bram_porta_addr, 10'h051);
    chk("rearm_done", sts_done, 1);
    chk("rearm_busy_end", sts_busy, 0);
    s_axis_tvalid = 1'b0;
    tick;
    chk("rearm_idle_busy", sts_busy, 0);

    // Async reset after 2 of 5 beats with a pending response
    cfg_base = 10'h060; cfg_length = 11'd5; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    s_axi_awaddr = 16'h0008; s_axi_wdata = 32'h77; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("ar_bvalid_pend", s_axi_bvalid, 1);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hD1;
    tick;
    chk("ar_beat0", bram_porta_addr, 10'h060);
    s_axis_tdata = 32'hD2;
    tick;
    chk("ar_beat1", bram_porta_addr, 10'h061);
    #2;
    areset = 1'b1;
    #1;
    chk("ar_bvalid", s_axi_bvalid, 0);
    chk("ar_tready", s_axis_tready, 0);
    chk("ar_busy", sts_busy, 0);
    chk("ar_done", sts_done, 0);
    chk("ar_addr", bram_porta_addr, 0);
    chk("ar_wrdata", bram_porta_wrdata, 0);
    chk("ar_we", bram_porta_we, 0);
    chk("ar_porta_rst", bram_porta_rst, 1);
    tick;
    areset = 1'b0;
    tick;
    chk("ar_post_tready", s_axis_tready, 0);
    chk("ar_post_done", sts_done, 0);
    chk("ar_post_busy", sts_busy, 0);
    chk("ar_post_state", dbg_state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
